// File: rtl/ifetch_pkg.sv
// typepkg: shared types and helpers for the 6502-style instruction fetch unit.
//   fetch_state_e         - fetch FSM state encoding
//   ins_length(opcode)    - instruction length in bytes (1..3) from the official
//                           6502 opcode map; BRK and unofficial opcodes are 1
package typepkg;

  typedef enum logic [2:0] {
    VEC_LO = 3'd0,
    VEC_HI = 3'd1,
    OPC    = 3'd2,
    ARG1   = 3'd3,
    ARG2   = 3'd4,
    HOLD   = 3'd5
  } fetch_state_e;

  function automatic logic [1:0] ins_length(input logic [7:0] opcode);
    logic [1:0] len;
    case (opcode)
      // (ind,X) and (ind),Y
      8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h71,
      8'h81, 8'h91, 8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1, 8'hF1,
      // zero page and zp,X (ORA..SBC column)
      8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h75,
      8'h85, 8'h95, 8'hA5, 8'hB5, 8'hC5, 8'hD5, 8'hE5, 8'hF5,
      // zero page shifts/INC/DEC/STX/LDX, including zp,Y forms 96 and B6
      8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 8'h66, 8'h76,
      8'h86, 8'h96, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6, 8'hF6,
      // zero page BIT/STY/LDY/CPY/CPX
      8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4,
      // immediate
      8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
      8'hA0, 8'hA2, 8'hC0, 8'hE0,
      // relative branches
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
        len = 2'd2;
      // absolute and abs,X (ORA..SBC column)
      8'h0D, 8'h1D, 8'h2D, 8'h3D, 8'h4D, 8'h5D, 8'h6D, 8'h7D,
      8'h8D, 8'h9D, 8'hAD, 8'hBD, 8'hCD, 8'hDD, 8'hED, 8'hFD,
      // abs,Y
      8'h19, 8'h39, 8'h59, 8'h79, 8'h99, 8'hB9, 8'hD9, 8'hF9,
      // absolute shifts/INC/DEC/STX/LDX (9E is unofficial)
      8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
      8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE,
      // JSR, BIT/JMP/JMP(ind)/STY/LDY/CPY/CPX absolute
      8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC, 8'hEC:
        len = 2'd3;
      default:
        len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Interfaces for the fetch unit.
//   ifetch_sys_if : clk (rising-edge system clock), reset (synchronous, active-high)
//   ifetch_bus_if : addr (16-bit fetch address, tri-stated when not driving),
//                   data (8-bit read data, returned combinationally by memory)
interface ifetch_sys_if;
  logic clk;
  logic reset;

  modport master (output clk, output reset);
  modport slave  (input  clk, input  reset);
endinterface

interface ifetch_bus_if;
  logic [15:0] addr;
  logic [7:0]  data;

  modport master (output addr, input  data);
  modport slave  (input  addr, output data);
endinterface

// File: rtl/ifetch.sv
// ifetch: fetches 6502 instructions byte by byte over a shared system bus and
// presents one complete instruction bundle at a time to the decoder.
//   sys.clk, sys.reset          - clock and synchronous active-high reset
//   sysbus.addr / sysbus.data   - fetch address out (z unless granted), read data in
//   bus_req / bus_gnt           - bus request out, grant for the current cycle in
//   ins_valid / ins_ready       - bundle handshake to the decoder
//   ins_op, ins_arg, ins_len, ins_pc - opcode, LE operands, length, opcode address
//   redir_valid / redir_pc      - redirect from execute
//
// state  | meaning
// VEC_LO | read reset vector low byte into pc[7:0]
// VEC_HI | read reset vector high byte into pc[15:8]
// OPC    | read opcode at pc, capture bundle pc and length
// ARG1   | read operand low byte
// ARG2   | read operand high byte
// HOLD   | bundle valid, bus released, wait for decoder
module ifetch
  import typepkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  ifetch_sys_if.slave   sys,
  ifetch_bus_if.master  sysbus,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [7:0]    ins_op,
  output logic [15:0]   ins_arg,
  output logic [1:0]    ins_len,
  output logic [15:0]   ins_pc,
  input  logic          redir_valid,
  input  logic [15:0]   redir_pc
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   op_q, op_d;
  logic [15:0]  arg_q, arg_d;
  logic [1:0]   len_q, len_d;
  logic [15:0]  ipc_q, ipc_d;
  logic [15:0]  fetch_addr;
  logic [1:0]   fetched_len;
  logic         redir_take;

  assign fetched_len = ins_length(sysbus.data);
  assign redir_take  = redir_valid && (state_q != VEC_LO) && (state_q != VEC_HI);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    arg_d      = arg_q;
    len_d      = len_q;
    ipc_d      = ipc_q;
    fetch_addr = pc_q;
    bus_req    = (state_q != HOLD);

    case (state_q)
      VEC_LO: begin
        fetch_addr = RESET_VEC;
        if (bus_gnt) begin
          pc_d[7:0] = sysbus.data;
          state_d   = VEC_HI;
        end
      end
      VEC_HI: begin
        fetch_addr = RESET_VEC + 16'd1;
        if (bus_gnt) begin
          pc_d[15:8] = sysbus.data;
          state_d    = OPC;
        end
      end
      OPC: begin
        if (bus_gnt) begin
          op_d    = sysbus.data;
          ipc_d   = pc_q;
          len_d   = fetched_len;
          arg_d   = 16'h0000;
          pc_d    = pc_q + 16'd1;
          state_d = (fetched_len == 2'd1) ? HOLD : ARG1;
        end
      end
      ARG1: begin
        if (bus_gnt) begin
          arg_d[7:0] = sysbus.data;
          pc_d       = pc_q + 16'd1;
          state_d    = (len_q == 2'd3) ? ARG2 : HOLD;
        end
      end
      ARG2: begin
        if (bus_gnt) begin
          arg_d[15:8] = sysbus.data;
          pc_d        = pc_q + 16'd1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (ins_ready) begin
          state_d = OPC;
        end
      end
      default: begin
        state_d = VEC_LO;
      end
    endcase

    // A redirect overrides whatever the bus cycle would have captured; the
    // held bundle registers stay as they are but are no longer valid.
    if (redir_take) begin
      state_d = OPC;
      pc_d    = redir_pc;
      op_d    = op_q;
      arg_d   = arg_q;
      len_d   = len_q;
      ipc_d   = ipc_q;
    end
  end

  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      state_q <= VEC_LO;
      pc_q    <= 16'h0000;
      op_q    <= 8'h00;
      arg_q   <= 16'h0000;
      len_q   <= 2'd1;
      ipc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
    end
  end

  // The address bus is shared, so it is only driven while we own it.
  assign sysbus.addr = (bus_gnt && bus_req) ? fetch_addr : 16'hzzzz;

  assign ins_valid = (state_q == HOLD);
  assign ins_op    = op_q;
  assign ins_arg   = arg_q;
  assign ins_len   = len_q;
  assign ins_pc    = ipc_q;

endmodule
